// File: rtl/x_500_mod_4051_loader.sv
// Word-serial assembler for the 500-bit X operand of x_500_mod_4051.
// Collects 16 LSW-first words and holds the finished operand stable until the consumer takes it.
module x_500_mod_4051_loader #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 16,
    parameter int X_W     = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD_W:1] in_data,
    input  logic            in_first,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [X_W:1]    out_x,
    output logic            out_trunc,
    output logic            resync_err
);

    localparam int CNT_W = $clog2(N_WORDS);
    localparam int LAST_W = X_W - (N_WORDS - 1) * WORD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             start_word;
    logic             resync;
    logic             store_next;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // in_first always wins, so a first flag in the last-word slot restarts rather than completes.
    always_comb begin
        next_state = state;
        start_word = 1'b0;
        resync     = 1'b0;
        store_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_first) begin
                    start_word = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (accept && in_first) begin
                    start_word = 1'b1;
                    resync     = 1'b1;
                end else if (accept) begin
                    store_next = 1'b1;
                    if (cnt == LAST_IDX) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            out_x      <= '0;
            out_trunc  <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            resync_err <= resync;
            if (start_word) begin
                out_x[WORD_W:1] <= in_data;
                cnt             <= CNT_W'(1);
                out_trunc       <= 1'b0;
            end else if (store_next) begin
                if (cnt == LAST_IDX) begin
                    // Only the low LAST_W bits of the top word fit into X.
                    out_x[X_W:X_W-LAST_W+1] <= in_data[LAST_W:1];
                    out_trunc               <= |in_data[WORD_W:LAST_W+1];
                    cnt                     <= '0;
                end else begin
                    for (int k = 1; k < N_WORDS - 1; k++) begin
                        if (cnt == CNT_W'(k)) begin
                            out_x[k*WORD_W+1 +: WORD_W] <= in_data;
                        end
                    end
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (state == HOLD && out_ready) begin
                out_trunc <= 1'b0;
            end
        end
    end

endmodule
